// File: rtl/icache_ctrl_pkg.sv
// Shared constants for the direct-mapped instruction cache: FSM state
// encodings, block geometry and a word-select helper.
package icache_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_READ = 2'd1;
    localparam logic [1:0] ST_UPDATE   = 2'd2;

    localparam int BLOCK_BYTES = 16;
    localparam int OFFSET_W    = 2;
    localparam int BLOCK_OFF_W = 4;
    localparam int BLOCK_W     = 128;

    // Picks 32-bit word 'off' out of a 128-bit block (word k at [32k+31:32k]).
    function automatic logic [31:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                              input logic [OFFSET_W-1:0] off);
        return blk[32*off +: 32];
    endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// Handshakes: the fetch side is served in the cycle read=1 and busywait=0;
// instruction is only meaningful then. The memory side holds mem_read=1 with a
// stable mem_address until a cycle with mem_busywait=0, in which mem_readdata
// is valid and the request completes.
interface icache_ctrl_if;
    logic         read;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    modport slave (
        input  read, address, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

    modport master (
        output read, address, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );
endinterface

// File: rtl/icache_ctrl_line_store.sv
// Line storage for the cache: valid bits (async clear), tag and data arrays
// (never reset). Combinational read port, synchronous write port.
module icache_line_store #(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [127:0]       rd_block_o,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [127:0]       wr_block_i
);
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [127:0]         data_q [NUM_LINES];

    // Valid bits clear asynchronously so a reset invalidates the whole cache at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data only matter behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_block_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_block_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hit path with zero
// added latency, IDLE -> MEM_READ -> UPDATE refill sequence on a miss.
// Optional feature macro: ICACHE_PERF_EN adds hit_count / miss_count outputs.
module icache_ctrl
    import icache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic          clk,
    input  logic          rst,
    icache_ctrl_if.slave  bus,
`ifdef ICACHE_PERF_EN
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count,
`endif
    output logic [1:0]    dbg_state
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - BLOCK_OFF_W - IDX_W;

    logic [1:0]         state_q, state_d;
    logic [27:0]        blk_addr_q, blk_addr_d;
    logic [127:0]       fill_q, fill_d;

    logic [IDX_W-1:0]   lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    logic [OFFSET_W-1:0] lookup_off;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [127:0]       line_block;
    logic               hit;
    logic               upd_we;
    logic               busywait_c;
    logic               mem_read_c;
    logic [31:0]        instr_c;

    assign lookup_off = bus.address[3:2];
    assign lookup_idx = bus.address[BLOCK_OFF_W +: IDX_W];
    assign lookup_tag = bus.address[31 -: TAG_W];

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (lookup_idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_block_o (line_block),
        .we_i       (upd_we),
        .wr_idx_i   (blk_addr_q[IDX_W-1:0]),
        .wr_tag_i   (blk_addr_q[27 -: TAG_W]),
        .wr_block_i (fill_q)
    );

    assign hit = bus.read & line_valid & (line_tag == lookup_tag);

    // Next-state and output decode; the fill always targets the latched block.
    always_comb begin
        state_d    = state_q;
        blk_addr_d = blk_addr_q;
        fill_d     = fill_q;
        upd_we     = 1'b0;
        busywait_c = 1'b0;
        mem_read_c = 1'b0;
        instr_c    = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (bus.read) begin
                    if (hit) begin
                        instr_c = word_sel(line_block, lookup_off);
                    end else begin
                        busywait_c = 1'b1;
                        blk_addr_d = bus.address[31:4];
                        state_d    = ST_MEM_READ;
                    end
                end
            end
            ST_MEM_READ: begin
                mem_read_c = 1'b1;
                busywait_c = 1'b1;
                if (!bus.mem_busywait) begin
                    fill_d  = bus.mem_readdata;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                busywait_c = 1'b1;
                upd_we     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset forces the fetch and memory outputs quiet immediately, even mid-fill.
    assign bus.busywait    = busywait_c & ~rst;
    assign bus.mem_read    = mem_read_c & ~rst;
    assign bus.instruction = rst ? 32'h0 : instr_c;
    assign bus.mem_address = blk_addr_q;
    assign dbg_state       = state_q;

    // FSM state and latched miss address; reset abandons any in-flight fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            blk_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            blk_addr_q <= blk_addr_d;
        end
    end

    // Captured memory block, held for the UPDATE write.
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Performance counters: served hits in IDLE and IDLE->MEM_READ transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (state_q == ST_IDLE && bus.read && !hit) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
